// File: rtl/div_unit.sv
// Radix-2 restoring divider for RV64M DIV/DIVU/REM/REMU; W variants under `DIV_WORD_OPS_EN`.
// Latency N+1 cycles (N = DATA_WIDTH or 32), special cases 1; no backpressure, start ignored while busy.
module div_unit #(
  parameter int DATA_WIDTH = 64
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_start,
  input  logic [1:0]            i_op,
  input  logic                  i_word,
  input  logic [DATA_WIDTH-1:0] i_dividend,
  input  logic [DATA_WIDTH-1:0] i_divisor,
  output logic                  o_busy,
  output logic                  o_valid,
  output logic [DATA_WIDTH-1:0] o_result
);

  localparam int W  = DATA_WIDTH;
  localparam int CW = $clog2(W + 1);

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [W-1:0]    rem_q, rem_d;
  logic [W-1:0]    quo_q, quo_d;
  logic [W-1:0]    dsr_q, dsr_d;
  logic [1:0]      op_q, op_d;
  logic            qneg_q, qneg_d;
  logic            rneg_q, rneg_d;
  logic [W-1:0]    result_q, result_d;
`ifdef DIV_WORD_OPS_EN
  logic            word_q, word_d;
`else
  logic            unused_word;
  assign unused_word = i_word;
`endif

  logic            signed_op, dvd_neg, dsr_neg, is_div0, is_ovf, res_neg;
  logic [W-1:0]    dvd_ext, dsr_ext, dvd_mag, dsr_mag, min_val, quo_init, spec_res;
  logic [CW-1:0]   n_iter;
  logic [W:0]      rem_shift, trial;
  logic [W-1:0]    rem_step, quo_step, sel_res, fin_res;

  // Operand preparation for the request presented this cycle.
  always_comb begin
    signed_op = ~i_op[0];
    dvd_ext   = i_dividend;
    dsr_ext   = i_divisor;
    min_val   = {1'b1, {(W-1){1'b0}}};
    n_iter    = CW'(W);
`ifdef DIV_WORD_OPS_EN
    if (i_word) begin
      dvd_ext = {{(W-32){signed_op & i_dividend[31]}}, i_dividend[31:0]};
      dsr_ext = {{(W-32){signed_op & i_divisor[31]}}, i_divisor[31:0]};
      min_val = {{(W-31){1'b1}}, 31'b0};
      n_iter  = CW'(32);
    end
`endif
    dvd_neg  = signed_op & dvd_ext[W-1];
    dsr_neg  = signed_op & dsr_ext[W-1];
    dvd_mag  = dvd_neg ? -dvd_ext : dvd_ext;
    dsr_mag  = dsr_neg ? -dsr_ext : dsr_ext;
    quo_init = dvd_mag;
    is_div0  = (dsr_ext == '0);
    is_ovf   = signed_op & (dvd_ext == min_val) & (dsr_ext == '1);
    if (is_div0) spec_res = i_op[1] ? dvd_ext : '1;
    else         spec_res = i_op[1] ? '0 : dvd_ext;
`ifdef DIV_WORD_OPS_EN
    // Word ops run on the top 32 bits so the dividend MSB shifts out first.
    if (i_word) begin
      quo_init = {dvd_mag[31:0], {(W-32){1'b0}}};
      spec_res = {{(W-32){spec_res[31]}}, spec_res[31:0]};
    end
`endif
  end

  // One restoring step plus the final sign fix-up applied on the last step.
  always_comb begin
    rem_shift = {rem_q, quo_q[W-1]};
    trial     = rem_shift - {1'b0, dsr_q};
    rem_step  = trial[W] ? rem_shift[W-1:0] : trial[W-1:0];
    quo_step  = {quo_q[W-2:0], ~trial[W]};
    sel_res   = op_q[1] ? rem_step : quo_step;
    res_neg   = ~op_q[0] & (op_q[1] ? rneg_q : qneg_q);
    fin_res   = res_neg ? -sel_res : sel_res;
`ifdef DIV_WORD_OPS_EN
    if (word_q) fin_res = {{(W-32){fin_res[31]}}, fin_res[31:0]};
`endif
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    rem_d    = rem_q;
    quo_d    = quo_q;
    dsr_d    = dsr_q;
    op_d     = op_q;
    qneg_d   = qneg_q;
    rneg_d   = rneg_q;
    result_d = result_q;
`ifdef DIV_WORD_OPS_EN
    word_d   = word_q;
`endif
    case (state_q)
      IDLE: begin
        if (i_start) begin
          op_d   = i_op;
          qneg_d = dvd_neg ^ dsr_neg;
          rneg_d = dvd_neg;
          dsr_d  = dsr_mag;
          rem_d  = '0;
          quo_d  = quo_init;
          cnt_d  = n_iter;
`ifdef DIV_WORD_OPS_EN
          word_d = i_word;
`endif
          if (is_div0 || is_ovf) begin
            result_d = spec_res;
            state_d  = DONE;
          end else begin
            state_d  = CALC;
          end
        end
      end
      CALC: begin
        rem_d = rem_step;
        quo_d = quo_step;
        cnt_d = cnt_q - CW'(1);
        if (cnt_q == CW'(1)) begin
          result_d = fin_res;
          state_d  = DONE;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      rem_q    <= '0;
      quo_q    <= '0;
      dsr_q    <= '0;
      op_q     <= '0;
      qneg_q   <= 1'b0;
      rneg_q   <= 1'b0;
      result_q <= '0;
`ifdef DIV_WORD_OPS_EN
      word_q   <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      rem_q    <= rem_d;
      quo_q    <= quo_d;
      dsr_q    <= dsr_d;
      op_q     <= op_d;
      qneg_q   <= qneg_d;
      rneg_q   <= rneg_d;
      result_q <= result_d;
`ifdef DIV_WORD_OPS_EN
      word_q   <= word_d;
`endif
    end
  end

  assign o_busy   = (state_q != IDLE);
  assign o_valid  = (state_q == DONE);
  assign o_result = result_q;

endmodule

// File: tb/tb_div_unit.sv
// Bench for div_unit: directed vector table, hand-written busy/reset sequences, random ops vs a reference model.
module tb_div_unit;

  logic        i_clk = 1'b0;
  logic        i_rst = 1'b1;
  logic        i_start = 1'b0;
  logic [1:0]  i_op = 2'b00;
  logic        i_word = 1'b0;
  logic [63:0] i_dividend = '0;
  logic [63:0] i_divisor = '0;
  logic        o_busy, o_valid;
  logic [63:0] o_result;

  int n_total = 0;
  int n_pass  = 0;

  div_unit #(.DATA_WIDTH(64)) dut (
    .i_clk(i_clk), .i_rst(i_rst), .i_start(i_start), .i_op(i_op), .i_word(i_word),
    .i_dividend(i_dividend), .i_divisor(i_divisor),
    .o_busy(o_busy), .o_valid(o_valid), .o_result(o_result)
  );

  always #5 i_clk = ~i_clk;

  typedef struct {
    logic [1:0]  op;
    logic        word;
    logic [63:0] a;
    logic [63:0] b;
    logic [63:0] exp;
    int          lat;
  } vec_t;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  // Reference: RISC-V division semantics with plain arithmetic.
  function automatic void model(input logic [1:0] op, input logic w, input logic [63:0] a,
                                input logic [63:0] b, output logic [63:0] r, output int lat);
    logic weff, sgn, rem;
    logic [31:0] a32, b32, r32;
    sgn = ~op[0];
    rem = op[1];
`ifdef DIV_WORD_OPS_EN
    weff = w;
`else
    weff = 1'b0 & w;
`endif
    lat = weff ? 33 : 65;
    if (weff) begin
      a32 = a[31:0];
      b32 = b[31:0];
      if (b32 == 0) begin
        r32 = rem ? a32 : 32'hFFFF_FFFF; lat = 1;
      end else if (sgn && a32 == 32'h8000_0000 && b32 == 32'hFFFF_FFFF) begin
        r32 = rem ? 32'h0 : a32; lat = 1;
      end else if (sgn) r32 = rem ? $signed(a32) % $signed(b32) : $signed(a32) / $signed(b32);
      else              r32 = rem ? a32 % b32 : a32 / b32;
      r = {{32{r32[31]}}, r32};
    end else begin
      if (b == 0) begin
        r = rem ? a : 64'hFFFF_FFFF_FFFF_FFFF; lat = 1;
      end else if (sgn && a == 64'h8000_0000_0000_0000 && b == 64'hFFFF_FFFF_FFFF_FFFF) begin
        r = rem ? 64'h0 : a; lat = 1;
      end else if (sgn) r = rem ? $signed(a) % $signed(b) : $signed(a) / $signed(b);
      else              r = rem ? a % b : a / b;
    end
  endfunction

  // Issues one request; returns result and the cycle offset of o_valid from the start cycle.
  task automatic run_op(input logic [1:0] op, input logic w, input logic [63:0] a,
                        input logic [63:0] b, output logic [63:0] res, output int lat);
    logic busy_ok;
    busy_ok = 1'b1;
    lat = -1;
    @(negedge i_clk);
    i_start = 1'b1; i_op = op; i_word = w; i_dividend = a; i_divisor = b;
    @(posedge i_clk); #1;
    i_start = 1'b0; i_op = ~op; i_word = ~w;
    i_dividend = {$urandom, $urandom}; i_divisor = {$urandom, $urandom};
    for (int k = 1; k <= 200; k++) begin
      if (!o_busy) busy_ok = 1'b0;
      if (o_valid) begin
        lat = k;
        break;
      end
      @(posedge i_clk); #1;
    end
    res = o_result;
    check("busy_during_op", {63'b0, busy_ok}, 64'd1);
    @(posedge i_clk); #1;
    check("valid_one_pulse", {63'b0, o_valid}, 64'd0);
    check("result_held", o_result, res);
  endtask

  vec_t vecs[11];
  logic [63:0] res, exp_r, a, b, first;
  int lat, exp_lat, n_valid;
  logic [1:0] op;
  logic w;

  initial begin
    vecs[0] = '{2'b01, 1'b0, 64'd100, 64'd7, 64'd14, 65};
    vecs[1] = '{2'b11, 1'b0, 64'd100, 64'd7, 64'd2, 65};
    vecs[2] = '{2'b00, 1'b0, -64'sd7, 64'd2, 64'hFFFF_FFFF_FFFF_FFFD, 65};
    vecs[3] = '{2'b10, 1'b0, -64'sd7, 64'd2, 64'hFFFF_FFFF_FFFF_FFFF, 65};
    vecs[4] = '{2'b10, 1'b0, 64'd7, -64'sd2, 64'd1, 65};
    vecs[5] = '{2'b00, 1'b0, 64'd5, 64'd0, 64'hFFFF_FFFF_FFFF_FFFF, 1};
    vecs[6] = '{2'b11, 1'b0, 64'd5, 64'd0, 64'd5, 1};
    vecs[7] = '{2'b00, 1'b0, 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 64'h8000_0000_0000_0000, 1};
    vecs[8] = '{2'b10, 1'b0, 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 64'd0, 1};
`ifdef DIV_WORD_OPS_EN
    vecs[9]  = '{2'b01, 1'b1, 64'h0000_0001_FFFF_FFFE, 64'd2, 64'h0000_0000_7FFF_FFFF, 33};
    vecs[10] = '{2'b00, 1'b1, 64'h0000_0001_FFFF_FFFE, 64'd2, 64'hFFFF_FFFF_FFFF_FFFF, 33};
`else
    vecs[9]  = '{2'b01, 1'b1, 64'h0000_0001_FFFF_FFFE, 64'd2, 64'h0000_0000_FFFF_FFFF, 65};
    vecs[10] = '{2'b00, 1'b1, 64'h0000_0001_FFFF_FFFE, 64'd2, 64'h0000_0000_FFFF_FFFF, 65};
`endif

    repeat (2) @(posedge i_clk);
    #1;
    check("reset_busy", {63'b0, o_busy}, 64'd0);
    check("reset_valid", {63'b0, o_valid}, 64'd0);
    check("reset_result", o_result, 64'd0);
    i_rst = 1'b0;

    foreach (vecs[i]) begin
      run_op(vecs[i].op, vecs[i].word, vecs[i].a, vecs[i].b, res, lat);
      check($sformatf("vec%0d_result", i), res, vecs[i].exp);
      check($sformatf("vec%0d_latency", i), 64'(lat), 64'(vecs[i].lat));
    end

    // Start while busy is ignored.
    @(negedge i_clk);
    i_start = 1'b1; i_op = 2'b01; i_word = 1'b0; i_dividend = 64'd100; i_divisor = 64'd7;
    @(posedge i_clk); #1;
    i_start = 1'b0;
    lat = -1;
    for (int k = 1; k <= 200; k++) begin
      if (k == 10) begin
        i_start = 1'b1; i_op = 2'b00; i_dividend = 64'd1000; i_divisor = 64'd3;
      end
      if (k == 11) i_start = 1'b0;
      if (o_valid) begin
        lat = k;
        break;
      end
      @(posedge i_clk); #1;
    end
    check("busy_ignore_result", o_result, 64'd14);
    check("busy_ignore_latency", 64'(lat), 64'd65);
    @(posedge i_clk); #1;
    check("busy_ignore_no_second", {63'b0, o_valid | o_busy}, 64'd0);

    // Reset in the middle of CALC aborts the operation.
    @(negedge i_clk);
    i_start = 1'b1; i_op = 2'b01; i_dividend = 64'd100; i_divisor = 64'd7;
    @(posedge i_clk); #1;
    i_start = 1'b0;
    repeat (19) @(posedge i_clk);
    #1;
    check("pre_rst_busy", {63'b0, o_busy}, 64'd1);
    i_rst = 1'b1;
    @(posedge i_clk); #1;
    i_rst = 1'b0;
    check("rst_busy", {63'b0, o_busy}, 64'd0);
    check("rst_result", o_result, 64'd0);
    n_valid = 0;
    for (int k = 0; k < 80; k++) begin
      if (o_valid || o_busy) n_valid++;
      @(posedge i_clk); #1;
    end
    check("rst_no_valid", 64'(n_valid), 64'd0);
    run_op(2'b01, 1'b0, 64'd1000, 64'd10, res, lat);
    check("post_rst_result", res, 64'd100);
    check("post_rst_latency", 64'(lat), 64'd65);

    // Randomized operations against the model.
    for (int i = 0; i < 40; i++) begin
      op = 2'($urandom_range(0, 3));
      w  = 1'($urandom_range(0, 1));
      a  = {$urandom, $urandom};
      case ($urandom_range(0, 5))
        0: b = 64'd0;
        1: b = 64'($urandom_range(1, 20));
        2: b = -64'($urandom_range(1, 20));
        3: b = {$urandom, $urandom};
        4: begin a = 64'h8000_0000_0000_0000; b = '1; end
        default: b = {32'd0, $urandom};
      endcase
      if (i % 7 == 3) begin a = {32'hDEAD_BEEF, 32'h8000_0000}; b = {32'h1234_5678, 32'hFFFF_FFFF}; end
      model(op, w, a, b, exp_r, exp_lat);
      run_op(op, w, a, b, res, lat);
      check($sformatf("rand%0d_result op=%0d w=%0d a=%h b=%h", i, op, w, a, b), res, exp_r);
      check($sformatf("rand%0d_latency", i), 64'(lat), 64'(exp_lat));
    end

    first = o_result;
    repeat (5) @(posedge i_clk);
    #1;
    check("idle_hold", o_result, first);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
